ula_controlador: RTL and testbench

- Upstream sequencer for the 8-bit ULA; it also collects the ULA's results.
- Buffers operation requests in a small FIFO, issues one at a time to the ULA, and holds a, b and opcode stable for the ULA's full pipeline.
- Captures s and flag after the fixed ULA latency and presents them on a valid/ready output port.
- Sits between the instruction source (testbench or control unit) and the ula instance.

---
 rtl/ula_pkg.sv | 31 +++
 rtl/ula_controlador_fila_instr.sv | 57 +++++
 rtl/ula_controlador.sv | 128 ++++++++++++
 tb/tb_ula_controlador.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ula_pkg.sv
// Shared definitions for the ULA sequencer: opcodes, FIFO entry layout and
// the controller state encoding.
package ula_pkg;

  localparam logic [2:0] OP_SOMA  = 3'b000;
  localparam logic [2:0] OP_SUB   = 3'b001;
  localparam logic [2:0] OP_XOR   = 3'b010;
  localparam logic [2:0] OP_NOT   = 3'b011;
  localparam logic [2:0] OP_IGUAL = 3'b110;
  localparam logic [2:0] OP_DIFER = 3'b111;

  localparam int LARG_ENTRADA = 19;

  typedef struct packed {
    logic [2:0] opcode;
    logic [7:0] a;
    logic [7:0] b;
  } entrada_t;

  typedef enum logic [1:0] {
    OCIOSO,
    ESPERA,
    PRONTO
  } estado_t;

  // Opcodes 100 and 101 have no ULA implementation and bypass the wait.
  function automatic logic op_invalida(input logic [2:0] op);
    return (op == 3'b100) || (op == 3'b101);
  endfunction

endpackage

// File: rtl/ula_controlador_fila_instr.sv
// Synchronous FIFO holding queued ULA requests; pointers wrap modulo PROF,
// so PROF must be a power of two.
module fila_instr #(
  parameter int PROF = 4,
  parameter int LARG = 19
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [LARG-1:0]          dado_in,
  output logic [LARG-1:0]          dado_out,
  output logic                     cheia,
  output logic                     vazia,
  output logic [$clog2(PROF):0]    contagem
);

  localparam int PW = $clog2(PROF);
  localparam logic [PW:0]   CHEIO  = (PW + 1)'(PROF);
  localparam logic [PW:0]   CNT_UM = (PW + 1)'(1);
  localparam logic [PW-1:0] PTR_UM = PW'(1);

  logic [LARG-1:0] mem [PROF];
  logic [PW-1:0]   ptr_esc;
  logic [PW-1:0]   ptr_lei;
  logic            push_ok;
  logic            pop_ok;

  assign cheia    = (contagem == CHEIO);
  assign vazia    = (contagem == '0);
  assign push_ok  = push && !cheia;
  assign pop_ok   = pop && !vazia;
  assign dado_out = mem[ptr_lei];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[ptr_esc] <= dado_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_esc  <= '0;
      ptr_lei  <= '0;
      contagem <= '0;
    end else begin
      if (push_ok) ptr_esc <= ptr_esc + PTR_UM;
      if (pop_ok)  ptr_lei <= ptr_lei + PTR_UM;
      case ({push_ok, pop_ok})
        2'b10:   contagem <= contagem + CNT_UM;
        2'b01:   contagem <= contagem - CNT_UM;
        default: contagem <= contagem;
      endcase
    end
  end

endmodule

// File: rtl/ula_controlador.sv
// Sequencer for the 8-bit ULA: queues requests, issues one at a time with
// operands held stable, and returns the captured result on a valid/ready port.
module ula_controlador
  import ula_pkg::*;
#(
  parameter int PROF     = 4,
  parameter int LATENCIA = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [2:0]             in_opcode,
  input  logic [7:0]             in_a,
  input  logic [7:0]             in_b,
  output logic [7:0]             ula_a,
  output logic [7:0]             ula_b,
  output logic [2:0]             ula_opcode,
  input  logic [7:0]             ula_s,
  input  logic                   ula_flag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [7:0]             out_s,
  output logic                   out_flag,
  output logic [2:0]             out_opcode,
  output logic                   out_invalida,
  output logic [$clog2(PROF):0]  ocupacao
);

  localparam int CW = $clog2(LATENCIA + 1);
  localparam logic [CW-1:0] CNT_FIM = CW'(LATENCIA);
  localparam logic [CW-1:0] CNT_UM  = CW'(1);

  estado_t   estado;
  estado_t   prox;
  entrada_t  entrada_fila;
  entrada_t  cabeca;
  logic      cheia;
  logic      vazia;
  logic      emitir;
  logic      capturar;
  logic [CW-1:0] cnt;
  logic [2:0]    op_copia;

  assign entrada_fila = {in_opcode, in_a, in_b};
  assign in_ready     = !cheia;

  fila_instr #(
    .PROF (PROF),
    .LARG (LARG_ENTRADA)
  ) u_fila (
    .clk      (clk),
    .rst      (rst),
    .push     (in_valid),
    .pop      (emitir),
    .dado_in  (entrada_fila),
    .dado_out (cabeca),
    .cheia    (cheia),
    .vazia    (vazia),
    .contagem (ocupacao)
  );

  always_comb begin
    prox      = estado;
    emitir    = 1'b0;
    capturar  = 1'b0;
    out_valid = 1'b0;
    case (estado)
      OCIOSO: begin
        if (!vazia) begin
          emitir = 1'b1;
          prox   = op_invalida(cabeca.opcode) ? PRONTO : ESPERA;
        end
      end
      ESPERA: begin
        if (cnt == CNT_FIM) begin
          capturar = 1'b1;
          prox     = PRONTO;
        end
      end
      PRONTO: begin
        out_valid = 1'b1;
        if (out_ready) prox = OCIOSO;
      end
      default: prox = OCIOSO;
    endcase
  end

  // Operands stay registered from issue until the next issue, so the ULA's
  // combinational flag is still coherent while the result waits in PRONTO.
  always_ff @(posedge clk) begin
    if (rst) begin
      estado       <= OCIOSO;
      cnt          <= '0;
      op_copia     <= '0;
      ula_a        <= '0;
      ula_b        <= '0;
      ula_opcode   <= '0;
      out_s        <= '0;
      out_flag     <= 1'b0;
      out_opcode   <= '0;
      out_invalida <= 1'b0;
    end else begin
      estado <= prox;
      if (emitir) begin
        ula_a      <= cabeca.a;
        ula_b      <= cabeca.b;
        ula_opcode <= cabeca.opcode;
        op_copia   <= cabeca.opcode;
        cnt        <= '0;
        if (op_invalida(cabeca.opcode)) begin
          out_s        <= '0;
          out_flag     <= 1'b0;
          out_opcode   <= cabeca.opcode;
          out_invalida <= 1'b1;
        end
      end else if (capturar) begin
        out_s        <= ula_s;
        out_flag     <= ula_flag;
        out_opcode   <= op_copia;
        out_invalida <= 1'b0;
      end else if (estado == ESPERA) begin
        cnt <= cnt + CNT_UM;
      end
    end
  end

endmodule

// File: tb/tb_ula_controlador.sv
// Scoreboard bench for ula_controlador with a behavioural two-stage ULA
// attached to its ula_* port.
module tb_ula_controlador;
  import ula_pkg::*;

  localparam int PROF     = 4;
  localparam int LATENCIA = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_opcode;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic [7:0] ula_a;
  logic [7:0] ula_b;
  logic [2:0] ula_opcode;
  logic [7:0] ula_s;
  logic       ula_flag;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_s;
  logic       out_flag;
  logic [2:0] out_opcode;
  logic       out_invalida;
  logic [$clog2(PROF):0] ocupacao;

  int checks = 0;
  int errors = 0;
  bit fim    = 1'b0;

  always #5 clk = ~clk;

  ula_controlador #(
    .PROF     (PROF),
    .LATENCIA (LATENCIA)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_opcode    (in_opcode),
    .in_a         (in_a),
    .in_b         (in_b),
    .ula_a        (ula_a),
    .ula_b        (ula_b),
    .ula_opcode   (ula_opcode),
    .ula_s        (ula_s),
    .ula_flag     (ula_flag),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_s        (out_s),
    .out_flag     (out_flag),
    .out_opcode   (out_opcode),
    .out_invalida (out_invalida),
    .ocupacao     (ocupacao)
  );

  // ULA stand-in: input register, then output register; flag is combinational
  // from the input register. Unimplemented opcodes produce deliberate garbage.
  logic [18:0] ula_reg_in;
  logic [7:0]  ula_s_reg;
  logic [8:0]  ula_prox;

  function automatic logic [8:0] ula_func(input logic [18:0] e);
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [8:0] r;
    op = e[18:16];
    a  = e[15:8];
    b  = e[7:0];
    case (op)
      3'b000:  r = {1'b0, a} + {1'b0, b};
      3'b001:  r = {1'b0, a} - {1'b0, b};
      3'b010:  r = {1'b0, a ^ b};
      3'b011:  r = {1'b0, ~a};
      3'b110:  r = {8'b0, a == b};
      3'b111:  r = {8'b0, a != b};
      default: r = {1'b1, a ^ 8'hA5};
    endcase
    return r;
  endfunction

  assign ula_prox = ula_func(ula_reg_in);
  assign ula_s    = ula_s_reg;
  assign ula_flag = ula_prox[8];

  always @(posedge clk) begin
    ula_reg_in <= {ula_opcode, ula_a, ula_b};
    ula_s_reg  <= ula_prox[7:0];
  end

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] s;
    logic       flag;
    logic       inv;
  } esp_t;

  esp_t fila_esp[$];
  esp_t cab;

  function automatic esp_t modelo(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    esp_t r;
    int x;
    int y;
    x      = a;
    y      = b;
    r.op   = op;
    r.a    = a;
    r.b    = b;
    r.s    = 8'h00;
    r.flag = 1'b0;
    r.inv  = 1'b0;
    case (op)
      OP_SOMA:  begin r.s = 8'((x + y) % 256);       r.flag = (x + y) > 255; end
      OP_SUB:   begin r.s = 8'((x - y + 256) % 256); r.flag = x < y;         end
      OP_XOR:   r.s = a ^ b;
      OP_NOT:   r.s = ~a;
      OP_IGUAL: r.s = (x == y) ? 8'd1 : 8'd0;
      OP_DIFER: r.s = (x != y) ? 8'd1 : 8'd0;
      default:  r.inv = 1'b1;
    endcase
    return r;
  endfunction

  task automatic checkOutput(input string nome, input logic [31:0] obtido, input logic [31:0] esperado);
    checks++;
    if (obtido !== esperado) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", nome, obtido, esperado);
    end
  endtask

  // Monitor: every cycle a result is presented it must match the oldest
  // outstanding request; accepted requests are scored as they enter.
  always @(negedge clk) begin
    if (rst) begin
      fila_esp.delete();
    end else begin
      if (out_valid) begin
        if (fila_esp.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL resultado_inesperado: out_valid=1 with no pending request");
        end else begin
          cab = fila_esp[0];
          checkOutput("resultado", {19'b0, out_opcode, out_invalida, out_flag, out_s},
                                   {19'b0, cab.op, cab.inv, cab.flag, cab.s});
          checkOutput("ula_entrada", {13'b0, ula_opcode, ula_a, ula_b},
                                     {13'b0, cab.op, cab.a, cab.b});
          if (out_ready) void'(fila_esp.pop_front());
        end
      end
      if (in_valid && in_ready) fila_esp.push_back(modelo(in_opcode, in_a, in_b));
    end
  end

  // Holds the request until accepted; returns #1 after the accepting edge.
  task automatic applyStimulus(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    int espera;
    espera    = 0;
    in_valid  = 1'b1;
    in_opcode = op;
    in_a      = a;
    in_b      = b;
    @(negedge clk);
    while (!in_ready && espera < 300) begin
      @(negedge clk);
      espera++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("[TB] FAIL timeout_entrada: in_ready=0 after %0d cycles, expected 1", espera);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic checkLatency(input string nome, input int esperado);
    int n;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 50) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    checkOutput(nome, n, esperado);
    @(posedge clk);
    #1;
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while (fila_esp.size() != 0 && n < 600) begin
      @(posedge clk);
      n++;
    end
    if (fila_esp.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL timeout_drenagem: %0d results pending, expected 0", fila_esp.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic checkResetState(input string nome);
    checkOutput({nome, "_ocupacao"}, 32'(ocupacao), 0);
    checkOutput({nome, "_in_ready"}, 32'(in_ready), 1);
    checkOutput({nome, "_out_valid"}, 32'(out_valid), 0);
    checkOutput({nome, "_saidas"},
                {19'b0, out_s, out_flag, out_opcode, out_invalida} | 32'({ula_a, ula_b, ula_opcode}), 0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_opcode = 3'b000;
    in_a      = 8'h00;
    in_b      = 8'h00;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkResetState("reset_inicial");
    @(posedge clk);
    #1;
    rst = 1'b0;

    $display("[TB] add with latency");
    out_ready = 1'b1;
    applyStimulus(OP_SOMA, 8'hC8, 8'h64);
    checkLatency("latencia_valida", LATENCIA + 2);
    waitDrain();

    $display("[TB] subtract both directions");
    applyStimulus(OP_SUB, 8'h05, 8'h0A);
    applyStimulus(OP_SUB, 8'h0A, 8'h05);
    waitDrain();

    $display("[TB] backpressure, ordering and stall");
    out_ready = 1'b0;
    applyStimulus(OP_XOR,   8'hF0, 8'h3C);
    applyStimulus(OP_NOT,   8'h0F, 8'h00);
    applyStimulus(OP_IGUAL, 8'h55, 8'h55);
    applyStimulus(OP_DIFER, 8'h55, 8'h55);
    applyStimulus(OP_SOMA,  8'h11, 8'h22);
    checkOutput("cheia_in_ready", 32'(in_ready), 0);
    checkOutput("cheia_ocupacao", 32'(ocupacao), PROF);
    repeat (10) begin
      @(negedge clk);
      checkOutput("stall_valid", 32'(out_valid), 1);
      checkOutput("stall_saida", {23'b0, out_flag, out_s}, {23'b0, 1'b0, 8'hCC});
      checkOutput("stall_ula", {13'b0, ula_opcode, ula_a, ula_b}, {13'b0, OP_XOR, 8'hF0, 8'h3C});
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    checkOutput("apos_handshake_valid", 32'(out_valid), 0);
    checkOutput("apos_handshake_ocupacao", 32'(ocupacao), PROF);
    @(negedge clk);
    checkOutput("proxima_emissao_ula", {13'b0, ula_opcode, ula_a, ula_b}, {13'b0, OP_NOT, 8'h0F, 8'h00});
    checkOutput("proxima_emissao_ocupacao", 32'(ocupacao), PROF - 1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    applyStimulus(OP_SUB, 8'h80, 8'h01);
    waitDrain();

    $display("[TB] invalid opcode");
    applyStimulus(3'b100, 8'h12, 8'h34);
    checkLatency("latencia_invalida", 1);
    applyStimulus(OP_XOR, 8'hAA, 8'h0F);
    applyStimulus(3'b101, 8'hFF, 8'hFF);
    applyStimulus(OP_SOMA, 8'hFF, 8'h01);
    waitDrain();

    $display("[TB] reset mid-operation");
    applyStimulus(OP_SOMA, 8'h01, 8'h02);
    applyStimulus(OP_SUB,  8'h03, 8'h04);
    applyStimulus(OP_XOR,  8'h05, 8'h06);
    applyStimulus(OP_NOT,  8'h07, 8'h08);
    checkOutput("pre_reset_ocupacao", 32'(ocupacao), 3);
    checkOutput("pre_reset_valid", 32'(out_valid), 0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkResetState("reset_meio");
    @(posedge clk);
    #1;

    $display("[TB] randomized traffic");
    fork
      begin
        for (int i = 0; i < 150; i++) begin
          applyStimulus(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
          end
        end
        fim = 1'b1;
      end
      begin
        while (!fim) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    waitDrain();
    checkOutput("fila_final_vazia", 32'(fila_esp.size()), 0);
    checkOutput("ocupacao_final", 32'(ocupacao), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
